sblk_row_inst_sched: RTL and testbench

- Instruction scheduler in front of the N_ROW superblock row.
- Accepts a valid/ready command stream from the top controller. Each command is one sblk instruction plus a row mask.
- Broadcasts each instruction to every masked row in the same cycle, and only once all of those rows are idle.
- Supports a barrier flag that drains the whole row before a command issues, and reports aggregate idle/issue status upward.

---
 rtl/sblk_sched_pkg.sv | 24 ++
 rtl/sblk_row_lock.sv | 45 ++++
 rtl/sblk_row_inst_sched.sv | 160 ++++++++++++++++
 tb/tb_sblk_row_inst_sched.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sblk_sched_pkg.sv
// sblk_sched_pkg: shared constants for the superblock row instruction scheduler.
//   - FSM state encodings (IDLE / CHECK / ISSUE)
//   - Command field offsets for the default geometry (N_ROW=8, WID_INST=14)
//   - Per-row lock counter width
package sblk_sched_pkg;

    localparam int N_ROW_DEF    = 8;
    localparam int WID_INST_DEF = 14;

    // cmd_data = {barrier, row_mask[N_ROW-1:0], inst[WID_INST-1:0]}
    localparam int INST_LSB    = 0;
    localparam int MASK_LSB    = WID_INST_DEF;
    localparam int BARRIER_BIT = WID_INST_DEF + N_ROW_DEF;

    // Holds STATUS_LAT, whose legal range is 1..7.
    localparam int LOCK_W = 3;

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t ST_IDLE  = 2'd0;
    localparam sched_state_t ST_CHECK = 2'd1;
    localparam sched_state_t ST_ISSUE = 2'd2;

endpackage

// File: rtl/sblk_row_lock.sv
// sblk_row_lock: per-row busy tracking.
// The sblk only raises its status STATUS_LAT cycles after a strobe, so a
// down-counter is loaded on each strobe and keeps the row marked busy until
// the real status can take over.
// Ports:
//   clk_i      clock
//   rst_n_i    asynchronous active-low reset
//   inst_en_i  issue strobe for this row (registered, from the scheduler)
//   status_i   sblk busy status for this row
//   busy_o     row is busy (status or lock window)
module sblk_row_lock
    import sblk_sched_pkg::*;
#(
    parameter int STATUS_LAT = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic inst_en_i,
    input  logic status_i,
    output logic busy_o
);

    logic [LOCK_W-1:0] lock_q;
    logic [LOCK_W-1:0] lock_d;

    always_comb begin
        lock_d = lock_q;
        if (inst_en_i) begin
            lock_d = LOCK_W'(STATUS_LAT);
        end else if (lock_q != '0) begin
            lock_d = lock_q - LOCK_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lock_q <= '0;
        end else begin
            lock_q <= lock_d;
        end
    end

    assign busy_o = status_i | (lock_q != '0);

endmodule

// File: rtl/sblk_row_inst_sched.sv
// sblk_row_inst_sched: instruction scheduler in front of the sblk row.
// Accepts one command at a time, holds it, and broadcasts the instruction to
// all masked rows in a single cycle once those rows (or, for a barrier, all
// rows) are free.
// Ports:
//   clk_l           clock (low-speed domain)
//   rst_n           asynchronous active-low reset
//   cmd_data        {barrier, row_mask, inst}
//   cmd_vld/cmd_rdy command handshake
//   status_sblk     per-row busy from the sblks
//   inst_data       per-row instruction, row r at [r*WID_INST +: WID_INST]
//   inst_en         per-row one-cycle issue strobe
//   row_idle        registered: FSM idle and all rows free
//   issue_cnt       issued commands (wraps)
//   perf_stall_cnt  CHECK stall cycles, saturating; only built when
//                   SBLK_SCHED_PERF_EN is defined, otherwise tied to 0
//
// state | meaning
// IDLE  | cmd_rdy=1, waiting for a command
// CHECK | command held, waiting for target rows (all rows if barrier) free
// ISSUE | inst_en pulses for the masked rows, back to IDLE
module sblk_row_inst_sched
    import sblk_sched_pkg::*;
#(
    parameter int N_ROW      = N_ROW_DEF,
    parameter int WID_INST   = WID_INST_DEF,
    parameter int STATUS_LAT = 2,
    parameter int WID_CMD    = WID_INST + N_ROW + 1
) (
    input  logic                      clk_l,
    input  logic                      rst_n,
    input  logic [WID_CMD-1:0]        cmd_data,
    input  logic                      cmd_vld,
    output logic                      cmd_rdy,
    input  logic [N_ROW-1:0]          status_sblk,
    output logic [WID_INST*N_ROW-1:0] inst_data,
    output logic [N_ROW-1:0]          inst_en,
    output logic                      row_idle,
    output logic [15:0]               issue_cnt,
    output logic [31:0]               perf_stall_cnt
);

    // Package offsets describe the default geometry; rebase them so that
    // overridden N_ROW / WID_INST still decode the right fields.
    localparam int C_INST_LSB = INST_LSB;
    localparam int C_MASK_LSB = MASK_LSB - WID_INST_DEF + WID_INST;
    localparam int C_BARRIER  = BARRIER_BIT - WID_INST_DEF - N_ROW_DEF + WID_INST + N_ROW;

    sched_state_t               state_q;
    sched_state_t               state_d;
    logic [WID_CMD-1:0]         cmd_q;
    logic                       cmd_rdy_q;
    logic [N_ROW-1:0]           inst_en_q;
    logic [WID_INST*N_ROW-1:0]  inst_data_q;
    logic [15:0]                issue_cnt_q;
    logic                       row_idle_q;
    logic [N_ROW-1:0]           busy;

    logic [WID_INST-1:0]        held_inst;
    logic [N_ROW-1:0]           held_mask;
    logic                       held_barrier;
    logic                       accept;
    logic                       issue_ok;
    logic                       do_issue;

    assign held_inst    = cmd_q[C_INST_LSB +: WID_INST];
    assign held_mask    = cmd_q[C_MASK_LSB +: N_ROW];
    assign held_barrier = cmd_q[C_BARRIER];

    assign accept   = cmd_vld & cmd_rdy_q;
    assign issue_ok = held_barrier ? (busy == '0) : ((held_mask & busy) == '0);
    // An empty mask is consumed straight from CHECK without a strobe.
    assign do_issue = (state_q == ST_CHECK) && issue_ok && (held_mask != '0);

    for (genvar r = 0; r < N_ROW; r++) begin : g_row
        sblk_row_lock #(
            .STATUS_LAT (STATUS_LAT)
        ) u_lock (
            .clk_i     (clk_l),
            .rst_n_i   (rst_n),
            .inst_en_i (inst_en_q[r]),
            .status_i  (status_sblk[r]),
            .busy_o    (busy[r])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (issue_ok) begin
                    state_d = (held_mask == '0) ? ST_IDLE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            inst_en_q   <= '0;
            inst_data_q <= '0;
            issue_cnt_q <= '0;
            row_idle_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            // Registered ready: high exactly while the FSM sits in IDLE.
            cmd_rdy_q  <= (state_d == ST_IDLE);
            inst_en_q  <= do_issue ? held_mask : '0;
            row_idle_q <= (state_q == ST_IDLE) && (busy == '0);
            if (accept) begin
                cmd_q <= cmd_data;
            end
            if (do_issue) begin
                issue_cnt_q <= issue_cnt_q + 16'd1;
            end
            for (int r = 0; r < N_ROW; r++) begin
                if (do_issue && held_mask[r]) begin
                    inst_data_q[r*WID_INST +: WID_INST] <= held_inst;
                end
            end
        end
    end

`ifdef SBLK_SCHED_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if ((state_q == ST_CHECK) && !issue_ok && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_stall_cnt = '0;
`endif

    assign cmd_rdy   = cmd_rdy_q;
    assign inst_en   = inst_en_q;
    assign inst_data = inst_data_q;
    assign issue_cnt = issue_cnt_q;
    assign row_idle  = row_idle_q;

endmodule

// File: tb/tb_sblk_row_inst_sched.sv
module tb_sblk_row_inst_sched;

    localparam int N_ROW      = 8;
    localparam int WID_INST   = 14;
    localparam int STATUS_LAT = 2;
    localparam int WID_CMD    = WID_INST + N_ROW + 1;
    localparam int NVEC       = 7;

    logic                      clk_l = 1'b0;
    logic                      rst_n = 1'b0;
    logic [WID_CMD-1:0]        cmd_data = '0;
    logic                      cmd_vld = 1'b0;
    logic                      cmd_rdy;
    logic [N_ROW-1:0]          status_sblk = '0;
    logic [WID_INST*N_ROW-1:0] inst_data;
    logic [N_ROW-1:0]          inst_en;
    logic                      row_idle;
    logic [15:0]               issue_cnt;
    logic [31:0]               perf_stall_cnt;

    always #5 clk_l = ~clk_l;

    sblk_row_inst_sched #(
        .N_ROW      (N_ROW),
        .WID_INST   (WID_INST),
        .STATUS_LAT (STATUS_LAT),
        .WID_CMD    (WID_CMD)
    ) dut (
        .clk_l          (clk_l),
        .rst_n          (rst_n),
        .cmd_data       (cmd_data),
        .cmd_vld        (cmd_vld),
        .cmd_rdy        (cmd_rdy),
        .status_sblk    (status_sblk),
        .inst_data      (inst_data),
        .inst_en        (inst_en),
        .row_idle       (row_idle),
        .issue_cnt      (issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    typedef struct {
        logic                barrier;
        logic [N_ROW-1:0]    mask;
        logic [WID_INST-1:0] inst;
        logic [N_ROW-1:0]    status;
        logic [N_ROW-1:0]    exp_en;   // 0 = no strobe expected
    } vec_t;

    vec_t                vecs [NVEC];
    int                  n_checks = 0;
    int                  n_pass = 0;
    logic [WID_INST-1:0] exp_data [N_ROW];
    logic [15:0]         exp_cnt = '0;
`ifdef SBLK_SCHED_PERF_EN
    localparam logic [31:0] EXP_STALL = 32'd10;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    task automatic step();
        @(posedge clk_l);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WID_INST*N_ROW-1:0] pack_exp();
        logic [WID_INST*N_ROW-1:0] v;
        for (int r = 0; r < N_ROW; r++) begin
            v[r*WID_INST +: WID_INST] = exp_data[r];
        end
        return v;
    endfunction

    function automatic void model_issue(input logic [N_ROW-1:0] mask, input logic [WID_INST-1:0] inst);
        for (int r = 0; r < N_ROW; r++) begin
            if (mask[r]) exp_data[r] = inst;
        end
        exp_cnt = exp_cnt + 16'd1;
    endfunction

    // Returns after the accept edge; the bench is then in cycle t+1.
    task automatic send_cmd(input logic barrier, input logic [N_ROW-1:0] mask,
                            input logic [WID_INST-1:0] inst);
        int n;
        n = 0;
        while (cmd_rdy !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("cmd_rdy_timeout", 128'(cmd_rdy), 128'(1));
        cmd_data = {barrier, mask, inst};
        cmd_vld  = 1'b1;
        step();
        cmd_vld  = 1'b0;
        cmd_data = ~{barrier, mask, inst};   // must be ignored once held
    endtask

    // lat is the cycle index of the strobe relative to the accept cycle t.
    task automatic wait_strobe(input int max_steps, output int lat, output logic [N_ROW-1:0] en);
        lat = 1;
        en  = '0;
        for (int i = 0; i < max_steps; i++) begin
            step();
            lat++;
            if (inst_en != '0) begin
                en = inst_en;
                return;
            end
        end
        lat = -1;
    endtask

    initial begin
        int                  lat;
        int                  gap;
        logic [N_ROW-1:0]    en;
        logic [N_ROW-1:0]    seen;

        for (int r = 0; r < N_ROW; r++) exp_data[r] = '0;

        vecs[0] = '{1'b0, 8'h05, 14'h1A3, 8'h00, 8'h05};
        vecs[1] = '{1'b0, 8'hF0, 14'h2B4, 8'h00, 8'hF0};
        vecs[2] = '{1'b0, 8'h0C, 14'h0F1, 8'h30, 8'h0C};  // busy rows outside mask
        vecs[3] = '{1'b1, 8'h81, 14'h3C5, 8'h00, 8'h81};  // barrier, all free
        vecs[4] = '{1'b0, 8'h01, 14'h155, 8'h80, 8'h01};  // non-barrier ignores row 7
        vecs[5] = '{1'b0, 8'h00, 14'h3FF, 8'h00, 8'h00};  // empty mask
        vecs[6] = '{1'b0, 8'hFF, 14'h2AA, 8'h00, 8'hFF};

        // Reset values
        repeat (2) step();
        chk("rst_cmd_rdy", 128'(cmd_rdy), 128'(0));
        chk("rst_inst_en", 128'(inst_en), 128'(0));
        chk("rst_inst_data", 128'(inst_data), 128'(0));
        chk("rst_issue_cnt", 128'(issue_cnt), 128'(0));
        chk("rst_perf", 128'(perf_stall_cnt), 128'(0));
        rst_n = 1'b1;
        step();
        chk("rel_row_idle", 128'(row_idle), 128'(1));
        chk("rel_cmd_rdy", 128'(cmd_rdy), 128'(1));

        // Table-driven single commands
        for (int i = 0; i < NVEC; i++) begin
            status_sblk = '0;
            repeat (4) step();
            chk($sformatf("v%0d_row_idle", i), 128'(row_idle), 128'(1));
            status_sblk = vecs[i].status;
            send_cmd(vecs[i].barrier, vecs[i].mask, vecs[i].inst);
            if (vecs[i].exp_en != '0) begin
                wait_strobe(8, lat, en);
                chk($sformatf("v%0d_en", i), 128'(en), 128'(vecs[i].exp_en));
                chk($sformatf("v%0d_lat", i), 128'(lat), 128'(2));
                model_issue(vecs[i].mask, vecs[i].inst);
                chk($sformatf("v%0d_issue_cnt", i), 128'(issue_cnt), 128'(exp_cnt));
                chk($sformatf("v%0d_inst_data", i), 128'(inst_data), 128'(pack_exp()));
                step();
                chk($sformatf("v%0d_once", i), 128'(inst_en), 128'(0));
            end else begin
                seen = inst_en;
                step();
                seen |= inst_en;
                chk($sformatf("v%0d_rdy_t2", i), 128'(cmd_rdy), 128'(1));
                repeat (3) begin
                    step();
                    seen |= inst_en;
                end
                chk($sformatf("v%0d_no_strobe", i), 128'(seen), 128'(0));
                chk($sformatf("v%0d_issue_cnt", i), 128'(issue_cnt), 128'(exp_cnt));
                chk($sformatf("v%0d_inst_data", i), 128'(inst_data), 128'(pack_exp()));
            end
        end
        status_sblk = '0;

        // Busy stall: row 2 busy for the first 10 CHECK cycles
        repeat (4) step();
        status_sblk = 8'h04;
        send_cmd(1'b0, 8'h04, 14'h0C3);
        seen = '0;
        for (int i = 0; i < 10; i++) begin
            seen |= inst_en;
            chk($sformatf("stall_rdy%0d", i), 128'(cmd_rdy), 128'(0));
            step();
        end
        chk("stall_no_strobe", 128'(seen | inst_en), 128'(0));
        status_sblk = 8'h00;
        step();
        chk("stall_en", 128'(inst_en), 128'(8'h04));
        model_issue(8'h04, 14'h0C3);
        chk("stall_data", 128'(inst_data), 128'(pack_exp()));
        chk("stall_perf", 128'(perf_stall_cnt), 128'(EXP_STALL));

        // Lock window: status never rises; lock is loaded with STATUS_LAT the
        // cycle after the strobe (c+1) and reaches 0 at c+3, so the
        // back-to-back command strobes at c+4.
        repeat (4) step();
        send_cmd(1'b0, 8'h01, 14'h0AA);
        wait_strobe(8, lat, en);
        chk("lock_first_en", 128'(en), 128'(8'h01));
        model_issue(8'h01, 14'h0AA);
        cmd_data = {1'b0, 8'h01, 14'h0BB};
        cmd_vld  = 1'b1;
        step();
        chk("lock_rdy_c1", 128'(cmd_rdy), 128'(1));
        step();
        cmd_vld = 1'b0;
        gap = 2;
        en  = '0;
        for (int i = 0; i < 8; i++) begin
            if (inst_en != '0) break;
            step();
            gap++;
        end
        en = inst_en;
        chk("lock_second_en", 128'(en), 128'(8'h01));
        chk("lock_gap", 128'(gap), 128'(4));
        model_issue(8'h01, 14'h0BB);
        chk("lock_data", 128'(inst_data), 128'(pack_exp()));

        // Barrier waits on row 7 even though only row 0 is targeted
        repeat (4) step();
        status_sblk = 8'h80;
        send_cmd(1'b1, 8'h01, 14'h2C7);
        seen = '0;
        repeat (3) begin
            seen |= inst_en;
            step();
        end
        seen |= inst_en;
        chk("bar_wait", 128'(seen), 128'(0));
        status_sblk = 8'h00;
        step();
        chk("bar_en", 128'(inst_en), 128'(8'h01));
        model_issue(8'h01, 14'h2C7);
        chk("bar_issue_cnt", 128'(issue_cnt), 128'(exp_cnt));

        // Reset while stalled in CHECK
        repeat (4) step();
        status_sblk = 8'h02;
        send_cmd(1'b0, 8'h02, 14'h111);
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", 128'(inst_en), 128'(0));
        chk("mid_rst_rdy", 128'(cmd_rdy), 128'(0));
        chk("mid_rst_cnt", 128'(issue_cnt), 128'(0));
        chk("mid_rst_data", 128'(inst_data), 128'(0));
        status_sblk = 8'h00;
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", 128'(row_idle), 128'(1));
        chk("post_rst_cnt", 128'(issue_cnt), 128'(0));
        seen = '0;
        repeat (6) begin
            step();
            seen |= inst_en;
        end
        chk("post_rst_no_issue", 128'(seen), 128'(0));
        chk("post_rst_rdy", 128'(cmd_rdy), 128'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
